laplace_window_gen: RTL

- Streaming front end for the 5-point Laplace datapath. Accepts a raster pixel stream, one pixel per handshake.
- Produces, per image pixel, the cross-shaped neighbourhood b (up), d (left), e (centre), f (right), h (down) consumed by the Laplace adder tree.
- Two internal line buffers; out-of-image neighbours are zero-padded.
- Exactly IMG_W*IMG_H windows per frame, in raster order of the centre pixel.

---
 rtl/laplace_window_gen_pkg.sv | 14 +
 rtl/laplace_window_gen_line_buf.sv | 33 +++
 rtl/laplace_window_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/laplace_window_gen_pkg.sv
// Shared types and defaults for the 5-point Laplace window generator.
package laplace_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_t;

endpackage

// File: rtl/laplace_window_gen_line_buf.sv
// One image line of storage: simple dual-port RAM with a registered read.
// A read of the address being written in the same cycle returns the new data.
module laplace_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port with write-to-read forwarding.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/laplace_window_gen.sv
// Streaming cross-shaped (b,d,e,f,h) window generator for the Laplace datapath.
// Row iy-1 is held in u_row1 and row iy-2 in u_row2. Reads are issued one
// step ahead (u_row1 two columns ahead) so the registered RAM outputs are
// ready when the next pixel is accepted; d/e come from a small shift pair.
// Optional build macro: LAPLACE_WIN_REPLICATE_EN selects edge replication of
// the centre pixel instead of zero padding for out-of-image neighbours.
module laplace_window_gen
  import laplace_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_d,
  output logic [PIX_W-1:0] out_e,
  output logic [PIX_W-1:0] out_f,
  output logic [PIX_W-1:0] out_h,
  output logic             out_first,
  output logic             out_last
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  win_state_t state, state_nxt;
  logic [XW-1:0] ix;
  logic [YW-1:0] iy;
  logic step, load, we;

  logic [XW:0]      ra1_sum, ra2_sum;
  logic [XW-1:0]    ra1, ra2;
  logic [PIX_W-1:0] rd1, rd2, cur_d, cur_e;
  logic [PIX_W-1:0] pad, win_b, win_d, win_f, win_h;
  logic             is_flush, at_top, at_left, at_right;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus handshake: step advances the column, load fills the output register.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    we        = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        step     = in_valid;
        we       = step;
        if (step && (ix == XMAX)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        step     = in_valid && in_ready;
        load     = step;
        we       = step;
        if (step && (ix == XMAX) && (iy == YMAX)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        step = !out_valid || out_ready;
        load = step;
        if (step && (ix == XMAX)) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Read-ahead addresses: row1 two columns ahead, row2 one column ahead, modulo IMG_W.
  always_comb begin
    ra1_sum = {1'b0, ix} + (XW+1)'(2);
    if (ra1_sum >= (XW+1)'(IMG_W)) begin
      ra1_sum = ra1_sum - (XW+1)'(IMG_W);
    end
    ra2_sum = {1'b0, ix} + (XW+1)'(1);
    if (ra2_sum >= (XW+1)'(IMG_W)) begin
      ra2_sum = ra2_sum - (XW+1)'(IMG_W);
    end
    ra1 = ra1_sum[XW-1:0];
    ra2 = ra2_sum[XW-1:0];
  end

  laplace_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_row1 (
    .clk   (clk),
    .we    (we),
    .waddr (ix),
    .wdata (in_pixel),
    .re    (step),
    .raddr (ra1),
    .rdata (rd1)
  );

  laplace_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_row2 (
    .clk   (clk),
    .we    (we),
    .waddr (ix),
    .wdata (cur_e),
    .re    (step),
    .raddr (ra2),
    .rdata (rd2)
  );

  // Window assembly with boundary handling for the current centre.
  always_comb begin
    is_flush = (state == FLUSH);
    at_top   = (state == RUN) && (iy == YW'(1));
    at_left  = (ix == '0);
    at_right = (ix == XMAX);
`ifdef LAPLACE_WIN_REPLICATE_EN
    pad = cur_e;
`else
    pad = '0;
`endif
    win_b = at_top   ? pad : rd2;
    win_d = at_left  ? pad : cur_d;
    win_f = at_right ? pad : rd1;
    win_h = is_flush ? pad : in_pixel;
  end

  // Column/row counters; row stays at 0 while the last row is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix <= '0;
      iy <= '0;
    end else if (step) begin
      if (ix == XMAX) begin
        ix <= '0;
        if (!is_flush) begin
          iy <= (iy == YMAX) ? '0 : iy + YW'(1);
        end
      end else begin
        ix <= ix + XW'(1);
      end
    end
  end

  // Shift the previous-row pixels so d and e track the current column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_d <= '0;
      cur_e <= '0;
    end else if (step) begin
      cur_d <= cur_e;
      cur_e <= rd1;
    end
  end

  // Output register: loads a new window, drains on out_ready, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_b     <= '0;
      out_d     <= '0;
      out_e     <= '0;
      out_f     <= '0;
      out_h     <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_b     <= win_b;
      out_d     <= win_d;
      out_e     <= cur_e;
      out_f     <= win_f;
      out_h     <= win_h;
      out_first <= at_top && at_left;
      out_last  <= is_flush && at_right;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
